ospi_target_ctrl: RTL and testbench
===================================

Name: ospi_target_ctrl

Overview:
- Parametrised, protocol-aware OSPI target (flash-like memory model) on the octal bus; successor to the passive, reset-only controller stub.
- Oversamples cs_n/sclk on the system clock, decodes opcode/address/dummy phases, and serves reads from and writes to an internal byte array.
- Drives dq/dqs through tri-states.
- Sits on the pin-level OSPI interface as the DUT for the UVM environment.

Parameters:
- DEPTH, 256, memory bytes; power of two, ≥ 2.
- ADDR_BYTES, 3, address bytes after opcode, 1..4; address taken modulo DEPTH.
- DUMMY_CYCLES, 8, sclk rising edges between the last address byte and read data, 0..31.
- RESET_FILL, 8'hFF, memory content after reset.

Ports:
- clk  input  1  system clock; must be ≥ 8× sclk frequency.
- rst  input  1  asynchronous, active-high reset.
- cs_n  input  1  chip select, active low, asynchronous to clk.
- sclk  input  1  OSPI serial clock, asynchronous to clk, idle low.
- dq  inout  8  octal data bus, SDR, one byte per sclk rising edge.
- dqs  inout  1  read strobe, driven only during the data-out phase.
- wel  output  1  write-enable latch, mirrors status bit 1.
- cmd_err  output  1  one-clk pulse on an unknown opcode or a write without WEL.

Behaviour:
- Reset (async, rst=1):
  - state IDLE; dq and dqs released (Z); wel=0; cmd_err=0; counters 0; all memory bytes = RESET_FILL.
  - Reset mid-frame aborts the frame immediately; outputs return to reset values in the same cycle.
- Synchronisation:
  - cs_n and sclk each pass through a 2-flop synchroniser plus edge detect.
  - Edge pulses appear 3 clk after the pin edge.
  - dq is sampled through a matching 2-flop delay so it is aligned with the sclk-rise pulse.
- States: IDLE, CMD, ADDR, DUMMY, DOUT, DIN, RDSR, IGNORE.
- Transitions:
  - IDLE→CMD on synced cs_n fall.
  - CMD: the first sclk rise captures the opcode.
  - 0x03 READ → ADDR.
  - 0x02 WRITE → ADDR if wel=1; otherwise pulse cmd_err and go to IGNORE.
  - 0x06 WREN: set wel, → IGNORE.
  - 0x04 WRDI: clear wel, → IGNORE.
  - 0x05 RDSR → RDSR.
  - Any other opcode: pulse cmd_err, → IGNORE.
  - ADDR: shift in ADDR_BYTES bytes, MSB first. Then READ → DUMMY, or DOUT directly when DUMMY_CYCLES=0; WRITE → DIN.
  - DUMMY: count DUMMY_CYCLES sclk rises, then → DOUT.
- DOUT:
  - On entry: enable dq, present mem[addr]; dqs driven 0.
  - Each synced sclk fall: addr increments (wraps DEPTH-1→0), the next byte is presented and dqs toggles.
  - The host samples on sclk rise. Byte k becomes valid no later than 4 clk after the k-th falling edge.
- DIN:
  - Each sclk rise writes the sampled byte to mem[addr], then addr increments with wrap.
  - The write is committed in the clk after the rise.
- RDSR: drive status {6'b0, wel, 1'b0 (WIP)} continuously with dqs toggling on each fall, same as DOUT.
- IGNORE: dq/dqs stay Z; all sclk edges are ignored until cs_n rises.
- Frame end:
  - Any synced cs_n rise returns to IDLE from any state and releases dq/dqs in the same clk.
  - Bytes already committed by a WRITE stay committed.
  - wel clears at the end of any frame that reached DIN, even if zero data bytes were written.
- cs_n rise during ADDR or DUMMY: no memory access, no cmd_err.
- Both sclk and cs_n edges detected in the same clk: the cs_n edge takes priority, and the sclk edge is discarded.
- dq/dqs are never driven outside DOUT or RDSR.

Decomposition:
- Package ospi_pkg:
  - opcode localparams OP_READ, OP_WRITE, OP_WREN, OP_WRDI, OP_RDSR;
  - typedef enum ospi_state_e for the states above;
  - status bit index constants SR_WIP=0, SR_WEL=1.
- Sub-module ospi_sync_edge: 2-flop synchroniser with registered rise/fall pulses. Instantiated once each for cs_n and sclk.

Test Plan:
- Reset then READ 0x03, addr 0x000010, 8 dummy, 4 bytes → dq returns FF,FF,FF,FF; dqs toggles 0→1→0→1; dq goes Z within 4 clk of cs_n rise.
- WREN 0x06 frame; WRITE 0x02 addr 0x0000FE with data A5,5A,C3 → mem[FE]=A5, mem[FF]=5A, mem[00]=C3 (wrap); a following RDSR returns 8'h00.
- WRITE without a prior WREN → cmd_err pulses once; the memory readback of the target addresses is unchanged (FF).
- Opcode 0x9F → cmd_err pulse; dq stays Z for the whole frame; the next READ frame behaves normally.
- WREN, then RDSR → 8'h02; then WRDI, then RDSR → 8'h00.
- rst asserted during DOUT after 2 bytes → dq/dqs Z immediately; wel=0; memory refilled to FF; the next READ at 0x10 returns FF.

Source files
------------

// File: rtl/ospi_pkg.sv
// ospi_pkg: shared opcodes, FSM state type and status-register layout for the OSPI target
package ospi_pkg;

    localparam logic [7:0] OP_WRITE = 8'h02;
    localparam logic [7:0] OP_READ  = 8'h03;
    localparam logic [7:0] OP_WRDI  = 8'h04;
    localparam logic [7:0] OP_RDSR  = 8'h05;
    localparam logic [7:0] OP_WREN  = 8'h06;

    localparam int SR_WIP = 0;
    localparam int SR_WEL = 1;

    typedef enum logic [2:0] {
        IDLE,
        CMD,
        ADDR,
        DUMMY,
        DOUT,
        DIN,
        RDSR,
        IGNORE
    } ospi_state_e;

    // Status register image; the model never has a write in progress.
    function automatic logic [7:0] status_byte(input logic wel);
        status_byte         = 8'h00;
        status_byte[SR_WEL] = wel;
        status_byte[SR_WIP] = 1'b0;
    endfunction

endpackage

// File: rtl/ospi_sync_edge.sv
// ospi_sync_edge: 2-flop synchroniser for an asynchronous pin with registered rise/fall pulses
module ospi_sync_edge #(
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic rise,
    output logic fall
);

    logic [2:0] sh_q, sh_d;
    logic       rise_q, rise_d;
    logic       fall_q, fall_d;

    // sh[0]/sh[1] form the synchroniser, sh[2] holds the previous synced level
    always_comb begin
        sh_d   = {sh_q[1:0], d};
        rise_d = sh_q[1] & ~sh_q[2];
        fall_d = ~sh_q[1] & sh_q[2];
    end

    // Pulses are registered so they appear three clk after the pin edge
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sh_q   <= {3{RST_VAL}};
            rise_q <= 1'b0;
            fall_q <= 1'b0;
        end else begin
            sh_q   <= sh_d;
            rise_q <= rise_d;
            fall_q <= fall_d;
        end
    end

    assign rise = rise_q;
    assign fall = fall_q;

endmodule

// File: rtl/ospi_target_ctrl.sv
// ospi_target_ctrl: oversampling OSPI flash-like target serving reads/writes from an internal byte array
module ospi_target_ctrl
    import ospi_pkg::*;
#(
    parameter int         DEPTH        = 256,
    parameter int         ADDR_BYTES   = 3,
    parameter int         DUMMY_CYCLES = 8,
    parameter logic [7:0] RESET_FILL   = 8'hFF
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       cs_n,
    input  logic       sclk,
    inout  wire  [7:0] dq,
    inout  wire        dqs,
    output logic       wel,
    output logic       cmd_err
);

    localparam int AW = $clog2(DEPTH);

    logic cs_rise, cs_fall, sck_rise, sck_fall;

    ospi_sync_edge #(.RST_VAL(1'b1)) u_cs_sync (
        .clk  (clk),
        .rst  (rst),
        .d    (cs_n),
        .rise (cs_rise),
        .fall (cs_fall)
    );

    ospi_sync_edge #(.RST_VAL(1'b0)) u_sclk_sync (
        .clk  (clk),
        .rst  (rst),
        .d    (sclk),
        .rise (sck_rise),
        .fall (sck_fall)
    );

    ospi_state_e     state_q, state_d;
    logic [AW-1:0]   addr_q, addr_d;
    logic [4:0]      cnt_q, cnt_d;
    logic            rd_q, rd_d;
    logic            wel_q, wel_d;
    logic            din_q, din_d;
    logic            turn_q, turn_d;
    logic            dqs_q, dqs_d;
    logic            err_q, err_d;
    logic [15:0]     dq_sync_q, dq_sync_d;
    logic [7:0]      mem_q [DEPTH];
    logic            mem_we;
    logic [7:0]      dq_in;
    logic            oe;
    logic [7:0]      dout;

    assign dq_in = dq_sync_q[15:8];

    // Frame decoder: cs_n edges pre-empt sclk edges seen in the same clk
    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        cnt_d     = cnt_q;
        rd_d      = rd_q;
        wel_d     = wel_q;
        din_d     = din_q;
        turn_d    = turn_q;
        dqs_d     = dqs_q;
        err_d     = 1'b0;
        mem_we    = 1'b0;
        dq_sync_d = {dq_sync_q[7:0], dq};
        if (cs_rise) begin
            state_d = IDLE;
            wel_d   = din_q ? 1'b0 : wel_q;
            din_d   = 1'b0;
        end else if (cs_fall) begin
            if (state_q == IDLE) begin
                state_d = CMD;
                addr_d  = '0;
                cnt_d   = '0;
                turn_d  = 1'b1;
                dqs_d   = 1'b0;
            end
        end else begin
            case (state_q)
                CMD: if (sck_rise) begin
                    case (dq_in)
                        OP_READ: begin
                            state_d = ADDR;
                            rd_d    = 1'b1;
                        end
                        OP_WRITE: begin
                            state_d = wel_q ? ADDR : IGNORE;
                            rd_d    = 1'b0;
                            err_d   = ~wel_q;
                        end
                        OP_WREN: begin
                            state_d = IGNORE;
                            wel_d   = 1'b1;
                        end
                        OP_WRDI: begin
                            state_d = IGNORE;
                            wel_d   = 1'b0;
                        end
                        OP_RDSR: state_d = RDSR;
                        default: begin
                            state_d = IGNORE;
                            err_d   = 1'b1;
                        end
                    endcase
                end
                ADDR: if (sck_rise) begin
                    addr_d = AW'({addr_q, dq_in});
                    cnt_d  = cnt_q + 5'd1;
                    if (cnt_q == 5'(ADDR_BYTES - 1)) begin
                        cnt_d   = '0;
                        state_d = !rd_q ? DIN : (DUMMY_CYCLES == 0 ? DOUT : DUMMY);
                        din_d   = !rd_q;
                    end
                end
                DUMMY: if (sck_rise) begin
                    cnt_d = cnt_q + 5'd1;
                    if (cnt_q == 5'(DUMMY_CYCLES - 1)) begin
                        cnt_d   = '0;
                        state_d = DOUT;
                    end
                end
                DOUT, RDSR: if (sck_fall) begin
                    // The fall closing the entry cycle is turnaround; byte 0 is sampled on the next rise
                    turn_d = 1'b0;
                    dqs_d  = turn_q ? dqs_q : ~dqs_q;
                    addr_d = (!turn_q && state_q == DOUT) ? addr_q + 1'b1 : addr_q;
                end
                DIN: if (sck_rise) begin
                    mem_we = 1'b1;
                    addr_d = addr_q + 1'b1;
                end
                default: ;
            endcase
        end
    end

    // Control state and input delay line
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            addr_q    <= '0;
            cnt_q     <= '0;
            rd_q      <= 1'b0;
            wel_q     <= 1'b0;
            din_q     <= 1'b0;
            turn_q    <= 1'b0;
            dqs_q     <= 1'b0;
            err_q     <= 1'b0;
            dq_sync_q <= '0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            cnt_q     <= cnt_d;
            rd_q      <= rd_d;
            wel_q     <= wel_d;
            din_q     <= din_d;
            turn_q    <= turn_d;
            dqs_q     <= dqs_d;
            err_q     <= err_d;
            dq_sync_q <= dq_sync_d;
        end
    end

    // Byte array, refilled on every reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= RESET_FILL;
        end else if (mem_we) begin
            mem_q[addr_q] <= dq_in;
        end
    end

    // Pin drivers are enabled purely from state so cs_n rise or reset releases them at once
    always_comb begin
        oe   = (state_q == DOUT) || (state_q == RDSR);
        dout = (state_q == RDSR) ? status_byte(wel_q) : mem_q[addr_q];
    end

    assign dq      = oe ? dout : 8'hzz;
    assign dqs     = oe ? dqs_q : 1'bz;
    assign wel     = wel_q;
    assign cmd_err = err_q;

endmodule

// File: tb/tb_ospi_target_ctrl.sv
// tb_ospi_target_ctrl: randomized frame-level host driving the OSPI target against a byte-array model
module tb_ospi_target_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       cs_n = 1'b1;
    logic       sclk = 1'b0;
    logic       host_oe = 1'b0;
    logic [7:0] host_dq = 8'h00;
    wire  [7:0] dq;
    wire        dqs;
    logic       wel, cmd_err;

    assign dq = host_oe ? host_dq : 8'hzz;
    for (genvar i = 0; i < 8; i++) begin : g_pd
        pulldown (dq[i]);
    end
    pullup (dqs);

    ospi_target_ctrl dut (
        .clk     (clk),
        .rst     (rst),
        .cs_n    (cs_n),
        .sclk    (sclk),
        .dq      (dq),
        .dqs     (dqs),
        .wel     (wel),
        .cmd_err (cmd_err)
    );

    always #5 clk = ~clk;

    int         vec = 0;
    int         bad = 0;
    int         err_seen = 0;
    int         err0 = 0;
    logic [7:0] mem_m [256];
    logic       wel_m = 1'b0;
    logic       chk_on = 1'b0;
    logic       exp_drv = 1'b0;
    logic [7:0] exp_dq = 8'h00;
    logic       exp_dqs = 1'b0;
    logic [8:0] rd_log [$];
    logic [7:0] wbuf [8];

    task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
        vec++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, got, exp, $time);
        end
    endtask

    // Released pins read as dq=00 (pulldown) and dqs=1 (pullup)
    always begin
        @(posedge clk);
        #2;
        if (cmd_err) err_seen++;
        if (chk_on) begin
            check("dq", 32'(dq), 32'(exp_drv ? exp_dq : 8'h00));
            check("dqs", 32'(dqs), 32'(exp_drv ? exp_dqs : 1'b1));
            check("wel", 32'(wel), 32'(wel_m));
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic win(input int n, input logic drv, input logic [7:0] d, input logic s);
        exp_drv = drv;
        exp_dq  = d;
        exp_dqs = s;
        chk_on  = 1'b1;
        tick(n);
        chk_on  = 1'b0;
    endtask

    task automatic send(input logic [7:0] b);
        host_dq = b;
        host_oe = 1'b1;
        tick(8);
        sclk = 1'b1;
        tick(3);
        host_oe = 1'b0;
        tick(5);
        sclk = 1'b0;
    endtask

    task automatic idle_cyc();
        host_oe = 1'b0;
        tick(5);
        win(3, 1'b0, 8'h00, 1'b0);
        sclk = 1'b1;
        tick(8);
        sclk = 1'b0;
    endtask

    task automatic recv(input logic [7:0] e, input logic s);
        host_oe = 1'b0;
        tick(5);
        win(3, 1'b1, e, s);
        rd_log.push_back({dqs, dq});
        sclk = 1'b1;
        tick(8);
        sclk = 1'b0;
    endtask

    task automatic cs_low();
        err0 = err_seen;
        cs_n = 1'b0;
        tick(8);
    endtask

    task automatic cs_high(input logic clr_wel, input int exp_err);
        sclk = 1'b0;
        host_oe = 1'b0;
        cs_n = 1'b1;
        tick(4);
        if (clr_wel) wel_m = 1'b0;
        win(4, 1'b0, 8'h00, 1'b0);
        check("cmd_err_pulses", 32'(err_seen - err0), 32'(exp_err));
        tick(4);
    endtask

    task automatic put_addr(input logic [23:0] a);
        send(a[23:16]);
        send(a[15:8]);
        send(a[7:0]);
    endtask

    task automatic do_read(input logic [23:0] a, input int n);
        cs_low();
        send(8'h03);
        put_addr(a);
        repeat (8) idle_cyc();
        for (int k = 0; k < n; k++) recv(mem_m[8'(a + 24'(k))], k[0]);
        cs_high(1'b0, 0);
    endtask

    task automatic do_write(input logic [23:0] a, input int n);
        logic ok;
        ok = wel_m;
        cs_low();
        send(8'h02);
        put_addr(a);
        for (int k = 0; k < n; k++) begin
            send(wbuf[k]);
            if (ok) mem_m[8'(a + 24'(k))] = wbuf[k];
        end
        cs_high(ok, ok ? 0 : 1);
    endtask

    task automatic do_cmd(input logic [7:0] op);
        cs_low();
        send(op);
        if (op == 8'h06) wel_m = 1'b1;
        if (op == 8'h04) wel_m = 1'b0;
        repeat (2) idle_cyc();
        cs_high(1'b0, (op == 8'h06 || op == 8'h04) ? 0 : 1);
    endtask

    task automatic do_rdsr(input int n);
        cs_low();
        send(8'h05);
        for (int k = 0; k < n; k++) recv({6'b0, wel_m, 1'b0}, k[0]);
        cs_high(1'b0, 0);
    endtask

    task automatic expect_log(input string nm, input int n, input logic [35:0] e);
        check({nm, "_len"}, 32'(rd_log.size()), 32'(n));
        for (int k = 0; k < n && k < rd_log.size(); k++)
            check(nm, 32'(rd_log[k]), 32'(e[35 - 9 * k -: 9]));
        rd_log = {};
    endtask

    initial begin
        #5_000_000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1);
    end

    initial begin
        logic [7:0]  op;
        logic [23:0] a;
        for (int i = 0; i < 256; i++) mem_m[i] = 8'hFF;
        tick(2);
        win(3, 1'b0, 8'h00, 1'b0);
        rst = 1'b0;
        tick(4);

        do_read(24'h000010, 4);
        expect_log("read_after_reset", 4, {9'h0FF, 9'h1FF, 9'h0FF, 9'h1FF});

        do_cmd(8'h06);
        wbuf[0] = 8'hA5; wbuf[1] = 8'h5A; wbuf[2] = 8'hC3;
        do_write(24'h0000FE, 3);
        do_rdsr(1);
        expect_log("rdsr_after_write", 1, {9'h000, 27'd0});
        do_read(24'h0000FE, 3);
        expect_log("wrap_write", 3, {9'h0A5, 9'h15A, 9'h0C3, 9'd0});

        wbuf[0] = 8'h12; wbuf[1] = 8'h34;
        do_write(24'h000040, 2);
        do_read(24'h000040, 2);
        expect_log("write_no_wel", 2, {9'h0FF, 9'h1FF, 18'd0});

        do_cmd(8'h9F);
        do_read(24'h000010, 1);
        expect_log("read_after_bad_op", 1, {9'h0FF, 27'd0});

        do_cmd(8'h06);
        do_rdsr(1);
        expect_log("rdsr_wel", 1, {9'h002, 27'd0});
        do_cmd(8'h04);
        do_rdsr(1);
        expect_log("rdsr_wrdi", 1, {9'h000, 27'd0});

        do_cmd(8'h06);
        wbuf[0] = 8'h11; wbuf[1] = 8'h22;
        do_write(24'h000010, 2);
        do_cmd(8'h06);
        cs_low();
        send(8'h03);
        put_addr(24'h000010);
        repeat (8) idle_cyc();
        recv(mem_m[8'h10], 1'b0);
        recv(mem_m[8'h11], 1'b1);
        expect_log("pre_reset_read", 2, {9'h011, 9'h122, 18'd0});
        host_oe = 1'b0;
        tick(2);
        rst = 1'b1;
        #1;
        check("rst_dq_release", 32'(dq), 32'h00);
        check("rst_dqs_release", 32'(dqs), 32'h1);
        check("rst_wel", 32'(wel), 32'h0);
        for (int i = 0; i < 256; i++) mem_m[i] = 8'hFF;
        wel_m = 1'b0;
        tick(3);
        rst = 1'b0;
        tick(2);
        cs_high(1'b0, 0);
        do_read(24'h000010, 1);
        expect_log("read_after_mid_reset", 1, {9'h0FF, 27'd0});

        for (int it = 0; it < 40; it++) begin
            a = 24'($urandom);
            case ($urandom_range(0, 8))
                0, 1: do_read(a, $urandom_range(0, 5));
                2, 3: begin
                    if ($urandom_range(0, 3) != 0) do_cmd(8'h06);
                    for (int k = 0; k < 8; k++) wbuf[k] = 8'($urandom);
                    do_write(a, $urandom_range(0, 4));
                end
                4: do_cmd(8'h06);
                5: do_cmd(8'h04);
                6: do_rdsr($urandom_range(1, 3));
                7: begin
                    op = 8'($urandom);
                    if (op inside {[8'h02:8'h06]}) op = 8'h9F;
                    do_cmd(op);
                end
                default: begin
                    cs_low();
                    send(8'h03);
                    send(a[7:0]);
                    if (a[8]) begin
                        send(a[15:8]);
                        send(a[23:16]);
                        repeat (3) idle_cyc();
                    end
                    cs_high(1'b0, 0);
                end
            endcase
        end
        rd_log = {};

        $display("== %0d vectors applied, %0d miscompares ==", vec, bad);
        $finish;
    end

endmodule
